jedro_1_decoder: RTL and testbench
==================================

JEDRO_1_DECODER -- requirements
Module: jedro_1_decoder

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 32; it is the operand and result width.
REQ-002 Parameter ALU_OP_WIDTH SHALL default to 4; it is the width of the ALU operation select.
REQ-003 Parameter REG_ADDR_WIDTH SHALL default to 5; it is the register file address width.
REQ-004 clk_i  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rstn_i  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 instr_i  in  32  SHALL carry the RV32I instruction word; it is sampled on handshake.
REQ-007 instr_valid_i  in  1  SHALL indicate that instr_i is valid.
REQ-008 instr_ready_o  out  1  SHALL indicate that the decoder accepts an instruction this cycle.
REQ-009 rf_addr_a_o, rf_addr_b_o  out  REG_ADDR_WIDTH  SHALL be the register file read addresses (rs1, rs2).
REQ-010 rf_data_a_i, rf_data_b_i  in  DATA_WIDTH  SHALL be the register file read data, valid one cycle after the address is sampled (synchronous read).
REQ-011 alu_op_sel_o  out  ALU_OP_WIDTH  SHALL be the ALU operation select.
REQ-012 opa_o, opb_o  out  DATA_WIDTH  SHALL be the ALU operands.
REQ-013 op_ready_o  out  1  SHALL be a one-cycle pulse marking alu_op_sel_o/opa_o/opb_o as valid.
REQ-014 rd_addr_o  out  REG_ADDR_WIDTH, rd_we_o  out  1  SHALL be the destination register and its write enable, both qualified by op_ready_o.
REQ-015 illegal_instr_o  out  1  SHALL be a one-cycle pulse flagging an undecodable instruction.

Function
REQ-016 The FSM SHALL have three states: IDLE, READ, ISSUE.
REQ-017 instr_ready_o SHALL be 1 only in IDLE.
REQ-018 In IDLE with instr_valid_i=1, the decoder SHALL latch instr_i at the edge and move to READ.
REQ-019 In READ, rf_addr_a_o/rf_addr_b_o SHALL be instr[19:15]/instr[24:20] of the latched word, and the next edge SHALL move to ISSUE.
REQ-020 At the edge leaving ISSUE, outputs SHALL be registered and the FSM SHALL return to IDLE; op_ready_o or illegal_instr_o SHALL then be 1 for exactly that one cycle.
REQ-021 Latency from the accept edge to op_ready_o high SHALL be 3 cycles; throughput SHALL be one instruction per 3 cycles.
REQ-022 Supported opcodes SHALL be OP (0110011), OP-IMM (0010011) and LUI (0110111).
REQ-023 alu_op_sel_o SHALL be {b, funct3}: b=funct7[5] for OP; for OP-IMM b=funct7[5] only when funct3=101, else 0; for LUI alu_op_sel_o=0000 (ADD).
REQ-024 OP: opa=rs1 data, opb=rs2 data; OP-IMM: opa=rs1 data, opb=sign-extended instr[31:20] (shifts: opb=zero-extended instr[24:20]); LUI: opa=0, opb={instr[31:12],12'b0}.
REQ-025 When rs1 or rs2 is 0, the corresponding operand SHALL be forced to 0 regardless of rf data.
REQ-026 Illegal SHALL mean: any other opcode; OP with funct7 not 0x00/0x20, or funct7=0x20 with funct3 not 000/101; OP-IMM funct3=001 with funct7≠0x00; OP-IMM funct3=101 with funct7 not 0x00/0x20.
REQ-027 Illegal instruction: illegal_instr_o=1, op_ready_o=0, rd_we_o=0, operands unchanged.
REQ-028 rd_addr_o SHALL be instr[11:7]; rd_we_o SHALL equal op_ready_o AND (rd≠0).
REQ-029 instr_valid_i while not in IDLE SHALL be ignored (not latched).

Reset
REQ-030 rstn_i=0 SHALL immediately, without a clock edge, force state IDLE and all outputs to 0 except instr_ready_o, which SHALL be 1.
REQ-031 Reset in READ or ISSUE SHALL abandon the instruction with no op_ready_o or illegal_instr_o pulse.

Verification
REQ-032 ADD x3,x1,x2 (0x002081B3), rf x1=5, x2=7 -> 3 cycles after accept: op_ready_o=1, alu_op_sel_o=0000, opa=5, opb=7, rd_addr=3, rd_we=1, for one cycle.
REQ-033 ADDI x5,x0,-1 (0xFFF00293), rf_data_a_i=0xDEADBEEF -> opa=0, opb=0xFFFFFFFF, alu_op_sel_o=0000.
REQ-034 SRAI x6,x6,4 (0x40435313) -> alu_op_sel_o=1101, opb=4.
REQ-035 LUI x7,0x12345 (0x123453B7) -> opa=0, opb=0x12345000, rd_we=1.
REQ-036 0x00000000 -> illegal_instr_o pulse, op_ready_o=0, instr_ready_o=1 the same cycle.
REQ-037 Accept ADD and assert rstn_i=0 mid-READ -> outputs 0 immediately, no pulse, instr_ready_o=1; the next instruction decodes normally.

Source files
------------

// File: rtl/jedro_1_decoder.sv
// RV32I integer decoder: accepts one instruction, reads rs1/rs2 from a synchronous
// register file and presents ALU operation select plus operands as a one-cycle pulse.
module jedro_1_decoder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_OP_WIDTH   = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [31:0]               instr_i,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_a_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_b_o,
  input  logic [DATA_WIDTH-1:0]     rf_data_a_i,
  input  logic [DATA_WIDTH-1:0]     rf_data_b_i,
  output logic [ALU_OP_WIDTH-1:0]   alu_op_sel_o,
  output logic [DATA_WIDTH-1:0]     opa_o,
  output logic [DATA_WIDTH-1:0]     opb_o,
  output logic                      op_ready_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      rd_we_o,
  output logic                      illegal_instr_o
);

  // state | meaning
  // IDLE  | waiting for an instruction, instr_ready_o high
  // READ  | rs1/rs2 addresses presented to the register file
  // ISSUE | register data available, result registered at the exit edge
  typedef enum logic [1:0] {IDLE, READ, ISSUE} state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  state_t state_q, state_d;
  logic [31:0] instr_q;

  logic [6:0] opcode, funct7;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] funct3;

  logic                    legal;
  logic [ALU_OP_WIDTH-1:0] alu_d;
  logic [DATA_WIDTH-1:0]   opa_d, opb_d, rs1_data, rs2_data;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign funct7 = instr_q[31:25];

  assign instr_ready_o = (state_q == IDLE);
  assign rf_addr_a_o   = REG_ADDR_WIDTH'(rs1);
  assign rf_addr_b_o   = REG_ADDR_WIDTH'(rs2);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && instr_valid_i) instr_q <= instr_i;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (instr_valid_i) state_d = READ;
      READ:    state_d = ISSUE;
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // x0 reads as zero no matter what the register file returns
  always_comb begin
    legal    = 1'b0;
    alu_d    = '0;
    opa_d    = '0;
    opb_d    = '0;
    rs1_data = (rs1 == 5'd0) ? '0 : rf_data_a_i;
    rs2_data = (rs2 == 5'd0) ? '0 : rf_data_b_i;
    case (opcode)
      OPC_OP: begin
        legal = (funct7 == 7'h00) ||
                (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
        alu_d = ALU_OP_WIDTH'({funct7[5], funct3});
        opa_d = rs1_data;
        opb_d = rs2_data;
      end
      OPC_OP_IMM: begin
        opa_d = rs1_data;
        if (funct3 == 3'b001) begin
          legal = (funct7 == 7'h00);
          alu_d = ALU_OP_WIDTH'({1'b0, funct3});
          opb_d = DATA_WIDTH'(instr_q[24:20]);
        end else if (funct3 == 3'b101) begin
          legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          alu_d = ALU_OP_WIDTH'({funct7[5], funct3});
          opb_d = DATA_WIDTH'(instr_q[24:20]);
        end else begin
          legal = 1'b1;
          alu_d = ALU_OP_WIDTH'({1'b0, funct3});
          opb_d = {{(DATA_WIDTH-12){instr_q[31]}}, instr_q[31:20]};
        end
      end
      OPC_LUI: begin
        legal = 1'b1;
        opb_d = DATA_WIDTH'({instr_q[31:12], 12'h000});
      end
      default: legal = 1'b0;
    endcase
  end

  // illegal words leave operand/op registers holding the previous result
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      alu_op_sel_o    <= '0;
      opa_o           <= '0;
      opb_o           <= '0;
      rd_addr_o       <= '0;
      rd_we_o         <= 1'b0;
      op_ready_o      <= 1'b0;
      illegal_instr_o <= 1'b0;
    end else begin
      op_ready_o      <= 1'b0;
      illegal_instr_o <= 1'b0;
      rd_we_o         <= 1'b0;
      if (state_q == ISSUE) begin
        if (legal) begin
          op_ready_o   <= 1'b1;
          alu_op_sel_o <= alu_d;
          opa_o        <= opa_d;
          opb_o        <= opb_d;
          rd_addr_o    <= REG_ADDR_WIDTH'(rd);
          rd_we_o      <= (rd != 5'd0);
        end else begin
          illegal_instr_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jedro_1_decoder.sv
// Randomized scoreboard bench for jedro_1_decoder against an RV32I-rule reference model.
module tb_jedro_1_decoder;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [4:0]  rf_addr_a_o, rf_addr_b_o, rd_addr_o;
  logic [31:0] rf_data_a_i = '0, rf_data_b_i = '0;
  logic [3:0]  alu_op_sel_o;
  logic [31:0] opa_o, opb_o;
  logic        op_ready_o, rd_we_o, illegal_instr_o;

  jedro_1_decoder dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .rf_addr_a_o(rf_addr_a_o), .rf_addr_b_o(rf_addr_b_o),
    .rf_data_a_i(rf_data_a_i), .rf_data_b_i(rf_data_b_i), .alu_op_sel_o(alu_op_sel_o),
    .opa_o(opa_o), .opb_o(opb_o), .op_ready_o(op_ready_o), .rd_addr_o(rd_addr_o),
    .rd_we_o(rd_we_o), .illegal_instr_o(illegal_instr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        illegal;
    logic [3:0]  alu;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  rd;
    logic        we;
    int          due;
  } exp_t;

  logic [31:0] regs [32];
  exp_t        exp_q[$];
  logic [31:0] last_opa = '0, last_opb = '0;
  int          cycle = 0;
  int          n_checks = 0, n_errors = 0;
  logic        prev_pulse = 1'b0;

  // synchronous-read register file
  always @(posedge clk_i) begin
    rf_data_a_i <= regs[rf_addr_a_o];
    rf_data_b_i <= regs[rf_addr_b_o];
    cycle++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t predict(input logic [31:0] ins);
    exp_t e;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a, b;
    f7 = ins[31:25];
    f3 = ins[14:12];
    a  = (ins[19:15] == 0) ? 32'd0 : regs[ins[19:15]];
    b  = (ins[24:20] == 0) ? 32'd0 : regs[ins[24:20]];
    e.illegal = 1'b1; e.alu = 4'd0; e.opa = a; e.opb = 32'd0;
    e.rd = ins[11:7]; e.due = 0;
    case (ins[6:0])
      7'b0110011: begin
        e.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        e.alu = {f7[5], f3};
        e.opb = b;
      end
      7'b0010011: begin
        if (f3 == 3'd1)      e.illegal = (f7 != 7'h00);
        else if (f3 == 3'd5) e.illegal = !(f7 == 7'h00 || f7 == 7'h20);
        else                 e.illegal = 1'b0;
        e.alu = {(f3 == 3'd5) ? f7[5] : 1'b0, f3};
        if (f3 == 3'd1 || f3 == 3'd5) e.opb = 32'(ins[24:20]);
        else                          e.opb = 32'($signed(ins[31:20]));
      end
      7'b0110111: begin
        e.illegal = 1'b0;
        e.opa = 32'd0;
        e.opb = {ins[31:12], 12'h000};
      end
      default: e.illegal = 1'b1;
    endcase
    if (e.illegal) begin
      e.opa = last_opa;
      e.opb = last_opb;
      e.we  = 1'b0;
    end else begin
      last_opa = e.opa;
      last_opb = e.opb;
      e.we = (e.rd != 0);
    end
    return e;
  endfunction

  function automatic logic [6:0] pick_f7();
    case ($urandom_range(0, 2))
      0:       return 7'h00;
      1:       return 7'h20;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [2:0]  f3;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return {pick_f7(), r[24:15], r[14:12], r[11:7], 7'b0110011};
      1: return {r[31:15], r[14:12], r[11:7], 7'b0010011};
      2: begin
        f3 = ($urandom_range(0, 1) != 0) ? 3'd5 : 3'd1;
        return {pick_f7(), r[24:15], f3, r[11:7], 7'b0010011};
      end
      3: return {r[31:12], r[11:7], 7'b0110111};
      4: return {7'h20, r[24:15], r[14:12], r[11:7], 7'b0110011};
      default: return r;
    endcase
  endfunction

  // waits for IDLE (junk valid while busy must be ignored), then hands over one word
  task automatic issue(input logic [31:0] ins);
    exp_t e;
    bit   ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (instr_ready_o) begin ok = 1; break; end
      instr_valid_i = 1'($urandom_range(0, 1));
      instr_i       = $urandom;
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL ready_timeout: got instr_ready 0 expected 1");
      return;
    end
    instr_valid_i = 1'b1;
    instr_i       = ins;
    e = predict(ins);
    e.due = cycle + 3;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    instr_valid_i = 1'b0;
    instr_i       = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_i);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr_ready"}, instr_ready_o, 1);
    check({tag, "_op_ready"}, op_ready_o, 0);
    check({tag, "_illegal"}, illegal_instr_o, 0);
    check({tag, "_rd_we"}, rd_we_o, 0);
    check({tag, "_alu"}, alu_op_sel_o, 0);
    check({tag, "_opa"}, opa_o, 0);
    check({tag, "_opb"}, opb_o, 0);
    check({tag, "_rd_addr"}, rd_addr_o, 0);
    check({tag, "_rf_addr_a"}, rf_addr_a_o, 0);
    check({tag, "_rf_addr_b"}, rf_addr_b_o, 0);
  endtask

  // monitor: one pop per output pulse
  always @(negedge clk_i) begin
    exp_t e;
    logic pulse;
    pulse = op_ready_o | illegal_instr_o;
    if (rstn_i && pulse) begin
      if (prev_pulse) check("pulse_width", {31'd0, prev_pulse}, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {31'd0, pulse}, 0);
      end else begin
        e = exp_q.pop_front();
        check("illegal", illegal_instr_o, e.illegal);
        check("op_ready", op_ready_o, !e.illegal);
        check("latency", cycle, e.due);
        check("ready_at_pulse", instr_ready_o, 1);
        check("rd_we", rd_we_o, e.we);
        check("opa", opa_o, e.opa);
        check("opb", opb_o, e.opb);
        if (!e.illegal) begin
          check("alu_op", alu_op_sel_o, e.alu);
          check("rd_addr", rd_addr_o, e.rd);
        end
      end
    end
    prev_pulse = rstn_i & pulse;
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hDEADBEEF;
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    #3;
    check_reset_outputs("por");
    @(negedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;

    issue(32'h002081B3);   // ADD  x3,x1,x2
    issue(32'hFFF00293);   // ADDI x5,x0,-1
    issue(32'h40435313);   // SRAI x6,x6,4
    issue(32'h123453B7);   // LUI  x7,0x12345
    issue(32'h00000000);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk_i);
      issue(rand_instr());
    end
    drain();

    // reset while the ADD is in READ
    issue(32'h002081B3);
    #2;
    rstn_i = 1'b0;
    #1;
    check_reset_outputs("mid_read");
    exp_q.delete();
    last_opa = '0;
    last_opb = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("no_pulse_in_reset", {31'd0, op_ready_o | illegal_instr_o}, 0);
    rstn_i = 1'b1;

    issue(32'h002081B3);
    for (int i = 0; i < 150; i++) issue(rand_instr());
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
